// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: shares WEN/RW/busW between pipeline writeback and a
// buffered MDU result stream, and tracks pending MDU destinations for decode RAW stalls.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_rw,
    input  logic [31:0] pipe_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rw,
    input  logic [31:0] mdu_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  chk_rs,
    input  logic [4:0]  chk_rt,
    output logic        raw_stall,
    output logic        pipe_hold,
    output logic        err,
    output logic        WEN,
    output logic [4:0]  RW,
    output logic [31:0] busW
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [4:0] STARVE_LIM = 5'(STARVE_MAX);

    typedef enum logic [0:0] {StNormal, StForce} state_e;

    state_e        r_state, w_state_d;
    logic [3:0]    r_starve, w_starve_d;
    logic [CW-1:0] r_count, w_count_d;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [4:0]    r_fifo_rw   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [31:0]   r_busy, w_busy_d;
    logic          r_err;
    logic          r_wen;
    logic [4:0]    r_rw;
    logic [31:0]   r_busw;

    logic          w_full, w_empty, w_push, w_pop;
    logic          w_pipe_req, w_pipe_win, w_iss_set, w_err_set;
    logic [4:0]    w_head_rw;
    logic [31:0]   w_head_data;
    logic [4:0]    w_starve_inc;

    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign mdu_ready   = !w_full;
    // Zero-destination results complete the handshake but are dropped.
    assign w_push      = mdu_valid && !w_full && (mdu_rw != 5'd0);
    assign w_head_rw   = r_fifo_rw[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    assign pipe_hold   = (r_state == StForce);
    assign w_pipe_req  = pipe_wen && (pipe_rw != 5'd0);
    assign w_pipe_win  = w_pipe_req && (r_state == StNormal);
    assign w_pop       = !w_pipe_win && !w_empty;
    assign w_iss_set   = iss_valid && (iss_rd != 5'd0);

    assign w_err_set = (w_pipe_req && pipe_hold)
                     || (w_iss_set && r_busy[iss_rd])
                     || (w_pop && !r_busy[w_head_rw]);

    assign raw_stall = r_busy[chk_rs] | r_busy[chk_rt];
    assign err       = r_err;
    assign WEN       = r_wen;
    assign RW        = r_rw;
    assign busW      = r_busw;

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_fifo_rw[r_wr_ptr]   <= mdu_rw;
            r_fifo_data[r_wr_ptr] <= mdu_data;
        end
    end

    always_comb begin
        w_count_d = r_count;
        if (w_push && !w_pop) begin
            w_count_d = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_d = r_count - CW'(1);
        end
    end

    assign w_starve_inc = {1'b0, r_starve} + 5'd1;

    always_comb begin
        w_state_d  = r_state;
        w_starve_d = r_starve;
        case (r_state)
            StNormal: begin
                if (w_pipe_win && !w_empty) begin
                    w_starve_d = w_starve_inc[3:0];
                    if (w_starve_inc >= STARVE_LIM) begin
                        w_state_d = StForce;
                    end
                end else begin
                    w_starve_d = '0;
                end
            end
            StForce: begin
                if (w_pop || w_empty) begin
                    w_state_d  = StNormal;
                    w_starve_d = '0;
                end
            end
            default: begin
                w_state_d  = StNormal;
                w_starve_d = '0;
            end
        endcase
    end

    // A same-cycle issue to the register being retired keeps it busy.
    always_comb begin
        w_busy_d = r_busy;
        if (w_pop) begin
            w_busy_d[w_head_rw] = 1'b0;
        end
        if (w_iss_set) begin
            w_busy_d[iss_rd] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_state  <= StNormal;
            r_starve <= '0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_busy   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_starve <= w_starve_d;
            r_count  <= w_count_d;
            r_busy   <= w_busy_d;
            r_err    <= r_err | w_err_set;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_wen  <= 1'b0;
            r_rw   <= '0;
            r_busw <= '0;
        end else if (w_pipe_win) begin
            r_wen  <= 1'b1;
            r_rw   <= pipe_rw;
            r_busw <= pipe_data;
        end else if (w_pop) begin
            r_wen  <= 1'b1;
            r_rw   <= w_head_rw;
            r_busw <= w_head_data;
        end else begin
            r_wen  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: every register-file write is matched in order
// against a queue of expected {RW, busW} pairs, plus point checks on control outputs.
module tb_regfile_wb_arbiter;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_MAX = 4;

    typedef struct packed {
        logic [4:0]  rw;
        logic [31:0] data;
    } wb_t;

    logic        Clk = 1'b0;
    logic        rst;
    logic        pipe_wen;
    logic [4:0]  pipe_rw;
    logic [31:0] pipe_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rw;
    logic [31:0] mdu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs;
    logic [4:0]  chk_rt;
    logic        raw_stall;
    logic        pipe_hold;
    logic        err;
    logic        WEN;
    logic [4:0]  RW;
    logic [31:0] busW;

    wb_t exp_q[$];
    wb_t exp_ent;
    int  n_checks = 0;
    int  n_fail   = 0;

    regfile_wb_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .Clk       (Clk),
        .rst       (rst),
        .pipe_wen  (pipe_wen),
        .pipe_rw   (pipe_rw),
        .pipe_data (pipe_data),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_rw    (mdu_rw),
        .mdu_data  (mdu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_rs    (chk_rs),
        .chk_rt    (chk_rt),
        .raw_stall (raw_stall),
        .pipe_hold (pipe_hold),
        .err       (err),
        .WEN       (WEN),
        .RW        (RW),
        .busW      (busW)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_wb(input logic [4:0] rw, input logic [31:0] data);
        wb_t e;
        e.rw   = rw;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drive_pipe(input logic [4:0] rw, input logic [31:0] data);
        pipe_wen  = 1'b1;
        pipe_rw   = rw;
        pipe_data = data;
        if (rw != 5'd0) expect_wb(rw, data);
    endtask

    // Scoreboard: every write that reaches the register file must be the next expected one.
    always @(negedge Clk) begin
        if (!rst && WEN) begin
            check("wb_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_ent = exp_q.pop_front();
                check("wb_rw", 32'(RW), 32'(exp_ent.rw));
                check("wb_data", busW, exp_ent.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        pipe_wen = 1'b0; pipe_rw = '0; pipe_data = '0;
        mdu_valid = 1'b0; mdu_rw = '0; mdu_data = '0;
        iss_valid = 1'b0; iss_rd = '0; chk_rs = '0; chk_rt = '0;
        tick(); tick();
        check("rst_wen", 32'(WEN), 32'd0);
        check("rst_rw", 32'(RW), 32'd0);
        check("rst_busw", busW, 32'd0);
        check("rst_hold", 32'(pipe_hold), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(mdu_ready), 32'd1);
        check("rst_stall", 32'(raw_stall), 32'd0);
        rst = 1'b0;
        tick();

        // Pipeline-only writes; r0 is never written.
        drive_pipe(5'd5, 32'hDEAD_BEEF);
        tick();
        check("pipe_wen", 32'(WEN), 32'd1);
        check("pipe_rw", 32'(RW), 32'd5);
        check("pipe_busw", busW, 32'hDEAD_BEEF);
        drive_pipe(5'd0, 32'h1111_1111);
        tick();
        check("pipe_r0_wen", 32'(WEN), 32'd0);
        check("pipe_r0_rw_hold", 32'(RW), 32'd5);
        check("pipe_r0_busw_hold", busW, 32'hDEAD_BEEF);
        pipe_wen = 1'b0;
        mdu_valid = 1'b1; mdu_rw = 5'd0; mdu_data = 32'h0000_BAD0;
        tick();
        mdu_valid = 1'b0;
        tick(); tick();
        check("mdu_r0_wen", 32'(WEN), 32'd0);
        check("mdu_r0_ready", 32'(mdu_ready), 32'd1);
        check("mdu_r0_err", 32'(err), 32'd0);

        // Scoreboard and MDU latency.
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        chk_rs = 5'd9; chk_rt = 5'd0; #1;
        check("sb_stall_rs", 32'(raw_stall), 32'd1);
        chk_rs = 5'd0; chk_rt = 5'd9; #1;
        check("sb_stall_rt", 32'(raw_stall), 32'd1);
        chk_rt = 5'd3; #1;
        check("sb_stall_other", 32'(raw_stall), 32'd0);
        chk_rs = 5'd9;
        mdu_valid = 1'b1; mdu_rw = 5'd9; mdu_data = 32'h0000_1234;
        expect_wb(5'd9, 32'h0000_1234);
        tick();
        mdu_valid = 1'b0;
        check("mdu_lat1_wen", 32'(WEN), 32'd0);
        check("mdu_lat1_stall", 32'(raw_stall), 32'd1);
        tick();
        check("mdu_lat2_wen", 32'(WEN), 32'd1);
        check("mdu_lat2_rw", 32'(RW), 32'd9);
        check("mdu_lat2_busw", busW, 32'h0000_1234);
        check("mdu_stall_drop", 32'(raw_stall), 32'd0);

        // Backpressure and forced drain.
        iss_valid = 1'b1; iss_rd = 5'd10;
        tick();
        iss_rd = 5'd11;
        tick();
        iss_valid = 1'b0;
        drive_pipe(5'd20, 32'hA000_0000);
        mdu_valid = 1'b1; mdu_rw = 5'd10; mdu_data = 32'hC000_000A;
        tick();
        drive_pipe(5'd21, 32'hA000_0001);
        mdu_rw = 5'd11; mdu_data = 32'hC000_000B;
        check("bp_ready_one", 32'(mdu_ready), 32'd1);
        tick();
        mdu_valid = 1'b0;
        check("bp_ready_full", 32'(mdu_ready), 32'd0);
        for (int i = 2; i < 5; i++) begin
            check("bp_no_hold", 32'(pipe_hold), 32'd0);
            drive_pipe(5'(20 + i), 32'hA000_0000 + 32'(i));
            tick();
        end
        check("bp_hold", 32'(pipe_hold), 32'd1);
        check("bp_last_pipe_rw", 32'(RW), 32'd24);
        pipe_wen = 1'b0;
        expect_wb(5'd10, 32'hC000_000A);
        tick();
        check("bp_hold_drop", 32'(pipe_hold), 32'd0);
        check("bp_force_rw", 32'(RW), 32'd10);
        check("bp_force_busw", busW, 32'hC000_000A);
        check("bp_ready_back", 32'(mdu_ready), 32'd1);
        drive_pipe(5'd25, 32'hA000_0005);
        tick();
        pipe_wen = 1'b0;
        expect_wb(5'd11, 32'hC000_000B);
        tick();
        tick();
        chk_rs = 5'd10; chk_rt = 5'd11; #1;
        check("bp_busy_clear", 32'(raw_stall), 32'd0);
        check("bp_err", 32'(err), 32'd0);

        // Issue and retire of the same register in one cycle.
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        mdu_valid = 1'b1; mdu_rw = 5'd7; mdu_data = 32'h0000_0077;
        expect_wb(5'd7, 32'h0000_0077);
        tick();
        mdu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        chk_rs = 5'd7; chk_rt = 5'd0; #1;
        check("col_wen", 32'(WEN), 32'd1);
        check("col_rw", 32'(RW), 32'd7);
        check("col_busy", 32'(raw_stall), 32'd1);

        // Reset with two results queued and traffic in flight.
        drive_pipe(5'd26, 32'hB000_0000);
        mdu_valid = 1'b1; mdu_rw = 5'd12; mdu_data = 32'hC000_000C;
        tick();
        drive_pipe(5'd27, 32'hB000_0001);
        mdu_rw = 5'd13; mdu_data = 32'hC000_000D;
        tick();
        mdu_valid = 1'b0;
        pipe_wen = 1'b0;
        check("mid_full", 32'(mdu_ready), 32'd0);
        rst = 1'b1; #1;
        exp_q.delete();
        check("mid_rst_wen", 32'(WEN), 32'd0);
        check("mid_rst_ready", 32'(mdu_ready), 32'd1);
        check("mid_rst_stall", 32'(raw_stall), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_hold", 32'(pipe_hold), 32'd0);
        tick();
        rst = 1'b0;
        chk_rs = 5'd0;
        tick();
        check("post_rst_wen", 32'(WEN), 32'd0);

        // Pipeline write attempted during a forced drain.
        iss_valid = 1'b1; iss_rd = 5'd14;
        tick();
        iss_valid = 1'b0;
        drive_pipe(5'd1, 32'hD000_0000);
        mdu_valid = 1'b1; mdu_rw = 5'd14; mdu_data = 32'hE000_000E;
        tick();
        mdu_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            drive_pipe(5'(1 + i), 32'hD000_0000 + 32'(i));
            tick();
        end
        check("hold_on", 32'(pipe_hold), 32'd1);
        check("hold_err_before", 32'(err), 32'd0);
        pipe_wen = 1'b1; pipe_rw = 5'd30; pipe_data = 32'h0BAD_0BAD;
        expect_wb(5'd14, 32'hE000_000E);
        tick();
        pipe_wen = 1'b0;
        check("hold_drain_rw", 32'(RW), 32'd14);
        check("hold_drain_busw", busW, 32'hE000_000E);
        check("hold_err", 32'(err), 32'd1);
        check("hold_off", 32'(pipe_hold), 32'd0);
        tick();

        // WAW: issue to an already pending register.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("waw_pre_err", 32'(err), 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        check("waw_first_err", 32'(err), 32'd0);
        tick();
        iss_valid = 1'b0;
        check("waw_err", 32'(err), 32'd1);
        tick(); tick(); tick();
        check("waw_err_sticky", 32'(err), 32'd1);
        rst = 1'b1; #1;
        check("waw_err_rst", 32'(err), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port (WEN/RW/busW) of the 32x32b MIPS register file.
- Shares that port between two writers: the in-order pipeline writeback stage, and the long-latency multiply/divide unit (MDU), which uses a valid/ready handshake.
- Keeps a busy scoreboard of registers whose MDU result is still pending, so decode can stall on RAW hazards.
- Forces MDU drain when the pipeline starves it.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of 2, >=2).
- STARVE_MAX, 4, consecutive pipeline wins with a non-empty FIFO before a hold is forced (1..15).

Ports:
- Clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- pipe_wen  in  1  pipeline writeback request.
- pipe_rw  in  5  pipeline destination register.
- pipe_data  in  32  pipeline write data.
- mdu_valid  in  1  MDU result valid.
- mdu_ready  out  1  FIFO can accept.
- mdu_rw  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- iss_valid  in  1  MDU op issued this cycle.
- iss_rd  in  5  destination register of the issued op.
- chk_rs  in  5  decode source register.
- chk_rt  in  5  decode source register.
- raw_stall  out  1  chk_rs or chk_rt is pending.
- pipe_hold  out  1  registered; pipeline must not write this cycle.
- err  out  1  sticky protocol error.
- WEN  out  1  register file write enable.
- RW  out  5  register file write address.
- busW  out  32  register file write data.

Behaviour:
- Reset (async, rst=1): WEN=0, RW=0, busW=0, pipe_hold=0, err=0, FIFO empty, busy=0, starve count=0, state=NORMAL. Reset asserted mid-operation discards all FIFO contents and pending bits immediately.
- Valid requests:
  - Pipeline request valid iff pipe_wen=1 and pipe_rw!=0.
  - An MDU result with mdu_rw=0 is accepted (handshake completes) but not pushed to the FIFO.
- Handshake:
  - mdu_ready = !full. It is combinational from registered FIFO count and does not depend on a same-cycle pop.
  - Push occurs on an edge with mdu_valid & mdu_ready.
  - A pushed entry becomes eligible for grant no earlier than the following cycle (no bypass).
  - Minimum MDU-to-WEN latency is 2 cycles.
- Grant, evaluated each cycle, result registered:
  - Valid pipeline request: WEN=1, RW=pipe_rw, busW=pipe_data on the next edge.
  - Else FIFO non-empty: pop head, WEN=1, RW/busW = head on the next edge.
  - Else WEN=0, with RW and busW holding their previous values.
  - Latency is exactly 1 cycle request-to-WEN.
- State machine:
  - NORMAL:
    - starve count increments when the pipeline wins while the FIFO is non-empty.
    - starve count clears when the FIFO wins or the FIFO is empty.
    - When the count would reach STARVE_MAX, the next state is FORCE and pipe_hold=1.
  - FORCE:
    - pipe_hold=1; FIFO head wins unconditionally.
    - After one pop, return to NORMAL with count=0 and pipe_hold=0.
    - A pipeline request seen while pipe_hold=1 is ignored (not written) and sets err.
- Scoreboard (busy[31:1], busy[0] tied 0):
  - iss_valid with iss_rd!=0 sets busy[iss_rd].
  - A FIFO grant clears busy[RW of popped entry].
  - Same-register set and clear in the same cycle: set wins.
  - iss_valid to a register already busy is a WAW violation: the bit stays set and err is set.
  - An MDU grant to a register that is not busy sets err.
- raw_stall = busy[chk_rs] | busy[chk_rt], combinational from registered busy. Register 0 never stalls.
- FIFO:
  - Pointer wrap-around is modulo DEPTH; count width is log2(DEPTH)+1.
  - Simultaneous push and pop when full is not possible, because ready=0 when full.
  - Simultaneous push and pop when non-full keeps the count unchanged.
- err is sticky until reset.

Test Plan:
- Reset: hold rst=1 mid-traffic with FIFO holding 2 entries -> WEN=0, mdu_ready=1, raw_stall=0 and busy cleared, on the same cycle as rst rises.
- Pipeline only: pipe_wen=1, pipe_rw=5, pipe_data=0xDEADBEEF at cycle n -> WEN=1, RW=5, busW=0xDEADBEEF at cycle n+1. pipe_rw=0 -> WEN=0.
- Scoreboard: iss_valid with iss_rd=9 -> raw_stall=1 for chk_rs=9 and for chk_rt=9. MDU returns rw=9, data=0x1234 on an idle pipeline -> WEN on cycle +2, raw_stall drops the cycle after the grant.
- Backpressure: push DEPTH=2 results with a continuous pipeline write -> mdu_ready=0 after the 2nd push. After STARVE_MAX=4 pipeline wins -> pipe_hold=1 for 1 cycle, FIFO head written, then NORMAL resumes.
- Errors: pipe_wen=1 while pipe_hold=1 -> no write and err=1. Issue rd=3 twice without a return -> err=1, persisting until rst.
- Collision: iss_valid rd=7 in the same cycle as FIFO grant of rw=7 -> busy[7] remains 1.
